// File: rtl/output_port_fifo.sv
// output_port_fifo: first-word-fall-through output-port buffer with valid/ready drain, last-write register and sticky overflow.
// Define OUTPUT_PORT_DROP_CNT_EN to add a saturating 16-bit dropped-write counter (drop_count).
module output_port_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] last_value,
    output logic [AW:0]      count,
    output logic             full,
    output logic             overflow
`ifdef OUTPUT_PORT_DROP_CNT_EN
   ,output logic [15:0]      drop_count
`endif
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             push, pop, drop;

    assign out_valid = count != '0;
    assign full      = count == (AW+1)'(DEPTH);
    assign pop       = out_valid & out_ready;
    // a pop frees the slot on the same edge, so a full FIFO can still take a write
    assign push      = wr_en & (~full | pop);
    assign drop      = wr_en & full & ~pop;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wr_data;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            last_value <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + AW'(1);
                last_value <= wr_data;
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (drop) overflow <= 1'b1;
        end

`ifdef OUTPUT_PORT_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) drop_count <= '0;
        else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
`endif
endmodule

// File: doc/output_port_fifo.md
Name: output_port_fifo

Overview:
- Parametrised, registered successor to the processor's combinational output stage.
- Buffers values the datapath writes to the output port in a first-word-fall-through (FWFT) FIFO.
- Presents the buffered values to an external consumer over a valid/ready handshake.
- Keeps a registered copy of the most recent write for debug/LED display, and flags writes lost to a full buffer.

Parameters:
- WIDTH, 32: data width in bits; data is treated as two's-complement signed.
- DEPTH, 4: FIFO entries; must be a power of two, >= 2.
- AW, $clog2(DEPTH): pointer width; derived, not to be overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  datapath write strobe; one value per cycle when high.
- wr_data  input  WIDTH  signed value to enqueue.
- out_data  output  WIDTH  signed head-of-FIFO value; valid only when out_valid=1.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- last_value  output  WIDTH  registered copy of the last accepted wr_data.
- count  output  AW+1  number of occupied entries, 0..DEPTH.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky; set when a write is dropped.

Behaviour:
- Reset (async, immediate on rst high):
  - read/write pointers = 0, count = 0, out_valid = 0, full = 0, overflow = 0, last_value = 0.
  - out_data is driven 0 while empty.
  - Reset mid-operation discards all buffered data; no partial handshake survives.
- Push: wr_en=1 and (full=0, or a pop occurs the same cycle) stores wr_data at wr_ptr and increments wr_ptr mod DEPTH. last_value <= wr_data on the same edge.
- Pop: out_valid=1 and out_ready=1 advances rd_ptr mod DEPTH.
- FWFT:
  - out_data = mem[rd_ptr], combinational from registered state.
  - A write to an empty FIFO makes out_valid=1 on the cycle after the write edge (latency 1).
  - No bypass of wr_data directly to out_data.
- Count:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged; both pointers advance.
- Full with simultaneous pop: the write is accepted and overflow is not set.
- Full without pop, wr_en=1:
  - the write is dropped; the FIFO and last_value are unchanged.
  - overflow <= 1 and stays 1 until rst.
- Empty with out_ready=1: no pop; pointers and count unchanged.
- Pointers wrap from DEPTH-1 to 0 without a stall or bubble.
- full and out_valid are derived from count; they never disagree with it.
- Handshake:
  - Once out_valid=1, out_data stays stable until popped.
  - The consumer may hold out_ready high continuously, giving 1 value per cycle sustained.
- Arithmetic: data is stored and passed bit-exact; no sign extension or truncation (a single WIDTH throughout).

Optional Feature:
- Macro: OUTPUT_PORT_DROP_CNT_EN.
- Defined:
  - adds output drop_count [15:0], reset 0.
  - increments by 1 on every dropped write (the same condition that sets overflow).
  - saturates at 16'hFFFF; no wrap.
- Undefined:
  - port and counter are absent.
  - overflow behaviour is unchanged.

Test Plan:
1. Reset/idle: assert rst mid-run with 3 entries queued -> count=0, out_valid=0, overflow=0, last_value=0 immediately, before the next clk edge.
2. FWFT latency: empty FIFO, write -5 (32'hFFFFFFFB) at edge N -> out_valid=1 and out_data=32'hFFFFFFFB after edge N; last_value=-5; pop with out_ready=1 -> out_valid=0 after the next edge.
3. Fill/drain order and wrap:
   - write 1,2,3,4 (DEPTH=4) -> full=1, count=4.
   - pop two, write 5,6 -> drain yields 3,4,5,6 in order, with pointers wrapped.
4. Overflow: full FIFO, wr_en=1 with value 99, out_ready=0 -> contents unchanged, last_value not 99, overflow=1 and stays 1 after the FIFO drains; with the macro defined, drop_count=1.
5. Simultaneous push/pop:
   - full FIFO, wr_en=1 and out_ready=1 -> count stays 4, no overflow, written value emerges 4 pops later.
   - empty FIFO with the same stimulus -> count=1, no pop.
6. Streaming: out_ready held 1, wr_en 1 for 20 cycles with values 0..19 -> 20 values out in order, count never exceeds 1, no overflow.
